// File: rtl/main_process_mul_arbiter.sv
// Round-robin time-share of one signed DIN_W x DIN_W multiplier among N_REQ requesters,
// each with a one-deep result slot. Define MUL_ARB_BUSY_CNT_EN to add the busy_cnt grant counter.
module main_process_mul_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DIN_W  = 16,
    parameter int unsigned DOUT_W = 28
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DIN_W-1:0]  req_a,
    input  logic [N_REQ*DIN_W-1:0]  req_b,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [N_REQ*DOUT_W-1:0] rsp_data
`ifdef MUL_ARB_BUSY_CNT_EN
    ,
    output logic [31:0]             busy_cnt
`endif
);
    localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PROD_W = 2 * DIN_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e              slot_q [N_REQ];
    slot_state_e              slot_d [N_REQ];
    logic [N_REQ*DOUT_W-1:0]  data_q;
    logic [N_REQ*DOUT_W-1:0]  data_d;
    logic [PTR_W-1:0]         ptr_q;
    logic [PTR_W-1:0]         ptr_d;
    logic [N_REQ-1:0]         elig;
    logic [N_REQ-1:0]         grant;
    logic [PTR_W-1:0]         gidx;
    logic                     found;
    int unsigned              cand;
    logic [DIN_W-1:0]         a_sel;
    logic [DIN_W-1:0]         b_sel;
    logic signed [PROD_W-1:0] prod;
    logic [DOUT_W-1:0]        prod_trunc;

    // Slot occupancy is the result-valid flag
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = (slot_q[i] == FULL);
        end
    end

    // A slot being drained this cycle may be refilled in the same cycle
    assign elig = req_valid & (~rsp_valid | rsp_ready);

    // Round-robin search starting at ptr_q, wrapping N_REQ-1 -> 0
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = 32'(ptr_q) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && elig[PTR_W'(cand)]) begin
                found = 1'b1;
                gidx  = PTR_W'(cand);
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    assign req_ready = grant & {N_REQ{ap_rst_n}};

    // Shared multiplier; the product keeps only the low DOUT_W bits
    assign a_sel      = req_a[32'(gidx) * DIN_W +: DIN_W];
    assign b_sel      = req_b[32'(gidx) * DIN_W +: DIN_W];
    assign prod       = $signed(PROD_W'($signed(a_sel))) * $signed(PROD_W'($signed(b_sel)));
    assign prod_trunc = prod[DOUT_W-1:0];
    assign rsp_data   = data_q;

    // Per-slot next state: a grant always wins over a drain
    always_comb begin
        ptr_d  = ptr_q;
        data_d = data_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            slot_d[i] = slot_q[i];
            case (slot_q[i])
                EMPTY: begin
                    if (grant[i]) begin
                        slot_d[i]                    = FULL;
                        data_d[i*DOUT_W +: DOUT_W]   = prod_trunc;
                    end
                end
                FULL: begin
                    if (grant[i]) begin
                        slot_d[i]                    = FULL;
                        data_d[i*DOUT_W +: DOUT_W]   = prod_trunc;
                    end else if (rsp_ready[i]) begin
                        slot_d[i]                    = EMPTY;
                    end
                end
            endcase
        end
        if (found) begin
            ptr_d = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                slot_q[i] <= EMPTY;
            end
            data_q <= '0;
            ptr_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                slot_q[i] <= slot_d[i];
            end
            data_q <= data_d;
            ptr_q  <= ptr_d;
        end
    end

`ifdef MUL_ARB_BUSY_CNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Accepted-product counter, wraps naturally at 2^32
    always_comb begin
        cnt_d = cnt_q;
        if (found) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_main_process_mul_arbiter.sv
// Scoreboard bench for main_process_mul_arbiter: a driver replays queued operand vectors,
// a monitor moves granted vectors to the expected queue and checks results as they drain.
module tb_main_process_mul_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int OW = 28;

    logic            ap_clk;
    logic            ap_rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [N*OW-1:0] rsp_data;
`ifdef MUL_ARB_BUSY_CNT_EN
    logic [31:0]     busy_cnt;
`endif

    main_process_mul_arbiter #(.N_REQ(N), .DIN_W(DW), .DOUT_W(OW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
`ifdef MUL_ARB_BUSY_CNT_EN
        ,
        .busy_cnt  (busy_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0]  slot;
        logic [15:0] a;
        logic [15:0] b;
        logic [27:0] exp;
    } vec_t;

    vec_t pend_q[$];
    vec_t exp_q[$];
    int   gl_idx[$];
    int   gl_cyc[$];
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   mon_j;
    logic drv_hit;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int s, input int a, input int b, input logic [27:0] e);
        vec_t v;
        v.slot = 2'(s);
        v.a    = 16'(a);
        v.b    = 16'(b);
        v.exp  = e;
        return v;
    endfunction

    // Driver: present the oldest pending vector of each slot
    always @(posedge ap_clk) begin
        #1;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            drv_hit = 1'b0;
            for (int k = 0; k < pend_q.size(); k++) begin
                if (!drv_hit && pend_q[k].slot == 2'(i)) begin
                    drv_hit = 1'b1;
                    req_valid[i] = 1'b1;
                    req_a[i*DW +: DW] = pend_q[k].a;
                    req_b[i*DW +: DW] = pend_q[k].b;
                end
            end
        end
    end

    // Monitor: check drained results, then record this cycle's grant
    always @(negedge ap_clk) begin
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
                mon_j = -1;
                for (int k = 0; k < exp_q.size(); k++)
                    if (mon_j < 0 && exp_q[k].slot == 2'(i)) mon_j = k;
                if (mon_j < 0) begin
                    check("unexpected_rsp", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    check("rsp_data", 32'(rsp_data[i*OW +: OW]), 32'(exp_q[mon_j].exp));
                    exp_q.delete(mon_j);
                end
            end
        end
        check("grant_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                mon_j = -1;
                for (int k = 0; k < pend_q.size(); k++)
                    if (mon_j < 0 && pend_q[k].slot == 2'(i)) mon_j = k;
                if (mon_j < 0) begin
                    check("spurious_grant", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    exp_q.push_back(pend_q[mon_j]);
                    pend_q.delete(mon_j);
                end
                gl_idx.push_back(i);
                gl_cyc.push_back(cyc);
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((pend_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge ap_clk);
            n++;
        end
        check(name, 32'(pend_q.size() + exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        pend_q.delete();
        exp_q.delete();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cyc = 0; n_cmp = 0; n_err = 0;
        ap_rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;

        // Reset: a waiting requester must not see ready
        pend_q.push_back(mk(3, 5, 6, 28'h000001E));
        repeat (3) @(negedge ap_clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < N; i++) check("rst_rsp_data", 32'(rsp_data[i*OW +: OW]), 32'd0);
`ifdef MUL_ARB_BUSY_CNT_EN
        check("rst_busy_cnt", busy_cnt, 32'd0);
`endif
        ap_rst_n = 1'b1;
        wait_idle(20, "rst_release_idle");

        // Single requester, 1-cycle latency
        @(negedge ap_clk);
        pend_q.push_back(mk(0, 3, -5, 28'hFFFFFF1));
        @(negedge ap_clk);
        check("t1_grant", 32'(req_ready), 32'h1);
        @(negedge ap_clk);
        check("t1_valid", 32'(rsp_valid[0]), 32'd1);
        check("t1_data", 32'(rsp_data[0 +: OW]), 32'h0FFFFFF1);
        wait_idle(20, "t1_idle");

        // Round-robin from ptr=0 with all four requesting
        do_reset();
        gl_idx.delete(); gl_cyc.delete();
        pend_q.push_back(mk(0, 2, 3, 28'h0000006));
        pend_q.push_back(mk(1, -4, 5, 28'hFFFFFEC));
        pend_q.push_back(mk(2, 100, 100, 28'h0002710));
        pend_q.push_back(mk(3, 1000, -1000, 28'hFF0BDC0));
        pend_q.push_back(mk(0, 7, -3, 28'hFFFFFEB));
        wait_idle(40, "t2_idle");
        check("t2_ngrant", 32'(gl_idx.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < gl_idx.size()) begin
                check("t2_order", 32'(gl_idx[k]), 32'(k % 4));
                check("t2_back2back", 32'(gl_cyc[k] - gl_cyc[0]), 32'(k));
            end
        end

        // Backpressure on slot 1, then same-cycle drain and refill
        rsp_ready = 4'b1101;
        pend_q.push_back(mk(1, 7, 9, 28'h000003F));
        pend_q.push_back(mk(1, 2, 2, 28'h0000004));
        @(negedge ap_clk);
        check("t3_grant", 32'(req_ready[1]), 32'd1);
        repeat (5) begin
            @(negedge ap_clk);
            check("t3_hold_valid", 32'(rsp_valid[1]), 32'd1);
            check("t3_hold_data", 32'(rsp_data[OW +: OW]), 32'd63);
            check("t3_ready_low", 32'(req_ready[1]), 32'd0);
        end
        @(posedge ap_clk);
        #2 rsp_ready[1] = 1'b1;
        @(negedge ap_clk);
        check("t3_refill_grant", 32'(req_ready[1]), 32'd1);
        @(negedge ap_clk);
        check("t3_refill_valid", 32'(rsp_valid[1]), 32'd1);
        check("t3_refill_data", 32'(rsp_data[OW +: OW]), 32'd4);
        wait_idle(20, "t3_idle");

        // Truncation corners
        pend_q.push_back(mk(2, -32768, -32768, 28'h0000000));
        pend_q.push_back(mk(2, 32767, -32768, 28'h0008000));
        pend_q.push_back(mk(2, -1, -1, 28'h0000001));
        wait_idle(30, "t4_idle");

        // Async reset with three results pending
        rsp_ready = '0;
        pend_q.push_back(mk(0, 1, 1, 28'h0000001));
        pend_q.push_back(mk(1, 2, 2, 28'h0000004));
        pend_q.push_back(mk(2, 3, 3, 28'h0000009));
        n = 0;
        while (pend_q.size() != 0 && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        @(negedge ap_clk);
        check("t5_full", 32'(rsp_valid), 32'h7);
        @(posedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) check("t5_async_data", 32'(rsp_data[i*OW +: OW]), 32'd0);
`ifdef MUL_ARB_BUSY_CNT_EN
        check("t5_async_busy_cnt", busy_cnt, 32'd0);
`endif
        exp_q.delete();
        pend_q.delete();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        rsp_ready = '1;
        gl_idx.delete(); gl_cyc.delete();
        pend_q.push_back(mk(3, 255, 255, 28'h000FE01));
        pend_q.push_back(mk(2, 12, -12, 28'hFFFFF70));
        pend_q.push_back(mk(1, -7, 8, 28'hFFFFFC8));
        wait_idle(30, "t5_idle");
        check("t5_ngrant", 32'(gl_idx.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            if (k < gl_idx.size()) check("t5_order", 32'(gl_idx[k]), 32'(k + 1));
`ifdef MUL_ARB_BUSY_CNT_EN
        check("t5_busy_cnt", busy_cnt, 32'd3);
`endif

        repeat (2) @(negedge ap_clk);
        check("final_queues", 32'(pend_q.size() + exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
